// File: rtl/countgen_mc.sv
// countgen_mc: per-channel PWM generator or rising-edge interval capture behind a Wishbone classic slave.
// Build option COUNTGEN_IRQ_EN turns address 3 into IRQ_MASK and adds the irq_o output.
module countgen_mc #(
    parameter int CHANNELS = 8,
    parameter int CNT_W    = 32,
    parameter int ADR_W    = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [ADR_W-1:0]    adr_i,
    input  logic [31:0]         dat_i,
    output logic [31:0]         dat_o,
    output logic                ack_o,
    inout  wire  [CHANNELS-1:0] countgen_io
`ifdef COUNTGEN_IRQ_EN
    ,
    output logic                irq_o
`endif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CHANNELS-1:0] enable, dir, status;
`ifdef COUNTGEN_IRQ_EN
    logic [CHANNELS-1:0] irq_mask;
`endif
    logic [CHANNELS-1:0] sync1, sync2, sync_prev;
    logic [CHANNELS-1:0] run_out, out_bit, cap_set, dir_chg, wrap, w1c;
    logic [CHANNELS-1:0] wr_period, wr_compare;
    logic [CNT_W-1:0]    period_sh  [CHANNELS];
    logic [CNT_W-1:0]    period_act [CHANNELS];
    logic [CNT_W-1:0]    compare    [CHANNELS];
    logic [CNT_W-1:0]    capture    [CHANNELS];
    logic [CNT_W-1:0]    count      [CHANNELS];

    logic             req, wr, is_glob, is_chan;
    logic [ADR_W-1:0] ch_off;
    logic [ADR_W-3:0] ch_idx;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign req         = cyc_i & stb_i & ~ack_o;
    assign wr          = req & we_i;
    assign ch_off      = adr_i - ADR_W'(4);
    assign ch_idx      = ch_off[ADR_W-1:2];
    assign is_glob     = adr_i < ADR_W'(4);
    assign is_chan     = !is_glob && (int'(ch_idx) < CHANNELS);
    assign unused_bits = ^{dat_i, ch_off[1:0]};

    always_comb begin
        rd_data    = '0;
        wr_period  = '0;
        wr_compare = '0;
        if (is_glob) begin
            case (adr_i[1:0])
                2'd0: rd_data = 32'(enable);
                2'd1: rd_data = 32'(dir);
                2'd2: rd_data = 32'(status);
`ifdef COUNTGEN_IRQ_EN
                2'd3: rd_data = 32'(irq_mask);
`endif
                default: rd_data = '0;
            endcase
        end else if (is_chan) begin
            for (int n = 0; n < CHANNELS; n++) begin
                if (int'(ch_idx) == n) begin
                    case (adr_i[1:0])
                        2'd0:    rd_data = 32'(period_sh[n]);
                        2'd1:    rd_data = 32'(compare[n]);
                        2'd2:    rd_data = 32'(capture[n]);
                        default: rd_data = 32'(count[n]);
                    endcase
                    wr_period[n]  = wr && (adr_i[1:0] == 2'd0);
                    wr_compare[n] = wr && (adr_i[1:0] == 2'd1);
                end
            end
        end
    end

    always_comb begin
        run_out = enable & dir;
        w1c     = (wr && adr_i == ADR_W'(2)) ? dat_i[CHANNELS-1:0] : '0;
        dir_chg = (wr && adr_i == ADR_W'(1)) ? (dat_i[CHANNELS-1:0] ^ dir) : '0;
        cap_set = sync2 & ~sync_prev & enable & ~dir & ~dir_chg;
        out_bit = '0;
        wrap    = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            out_bit[n] = enable[n] && (period_act[n] != '0) && (count[n] < compare[n]);
            wrap[n]    = run_out[n] && (period_act[n] != '0) &&
                         (count[n] >= period_act[n] - CNT_W'(1));
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_pin
        assign countgen_io[n] = dir[n] ? out_bit[n] : 1'bz;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            enable <= '0;
            dir    <= '0;
            status <= '0;
`ifdef COUNTGEN_IRQ_EN
            irq_mask <= '0;
            irq_o    <= 1'b0;
`endif
        end else begin
            ack_o  <= req;
            dat_o  <= req ? rd_data : '0;
            // a capture landing in the same cycle as the clear must not be lost
            status <= (status & ~w1c) | cap_set;
            if (wr && adr_i == ADR_W'(0)) enable <= dat_i[CHANNELS-1:0];
            if (wr && adr_i == ADR_W'(1)) dir <= dat_i[CHANNELS-1:0];
`ifdef COUNTGEN_IRQ_EN
            if (wr && adr_i == ADR_W'(3)) irq_mask <= dat_i[CHANNELS-1:0];
            irq_o <= |(status & irq_mask);
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1     <= '0;
            sync2     <= '0;
            sync_prev <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                period_sh[n]  <= '0;
                period_act[n] <= '0;
                compare[n]    <= '0;
                capture[n]    <= '0;
                count[n]      <= '0;
            end
        end else begin
            for (int n = 0; n < CHANNELS; n++) begin
                // presetting the history high means only a genuine low-to-high after the flip counts
                if (dir_chg[n]) begin
                    sync1[n]     <= 1'b1;
                    sync2[n]     <= 1'b1;
                    sync_prev[n] <= 1'b1;
                end else begin
                    sync1[n]     <= countgen_io[n];
                    sync2[n]     <= sync1[n];
                    sync_prev[n] <= sync2[n];
                end

                if (dir_chg[n] || !enable[n] || wrap[n] || (run_out[n] && period_act[n] == '0))
                    count[n] <= '0;
                else if (run_out[n])
                    count[n] <= count[n] + CNT_W'(1);
                else if (cap_set[n]) begin
                    capture[n] <= (count[n] == CNT_MAX) ? CNT_MAX : count[n] + CNT_W'(1);
                    count[n]   <= '0;
                end else if (count[n] != CNT_MAX)
                    count[n] <= count[n] + CNT_W'(1);

                if (wr_period[n]) period_sh[n] <= dat_i[CNT_W-1:0];
                if (wr_period[n] && (!run_out[n] || period_act[n] == '0))
                    period_act[n] <= dat_i[CNT_W-1:0];
                else if (!run_out[n] || wrap[n])
                    period_act[n] <= period_sh[n];

                if (wr_compare[n]) compare[n] <= dat_i[CNT_W-1:0];
            end
        end
    end
endmodule
